// File: rtl/div_rs32.sv
// Sequential radix-2 shift-subtract divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Operands and results use valid/ready handshakes; one quotient bit is resolved per cycle.
module div_rs32 #(
    parameter int XLEN = 32,
    parameter int CW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            sgn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   counter;
    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] dvs;
    logic            ns1;
    logic            ns2;

    logic            neg1_in;
    logic            neg2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;
    logic            div_zero;
    logic            overflow;
    logic            last_iter;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign neg1_in  = sgn & op1[XLEN-1];
    assign neg2_in  = sgn & op2[XLEN-1];
    assign mag1_in  = neg1_in ? -op1 : op1;
    assign mag2_in  = neg2_in ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign overflow = sgn && (op1 == MIN_NEG) && (op2 == '1);

    // Trial subtraction on the shifted partial remainder; the extra top bit is the borrow.
    assign trial     = {r, q[XLEN-1]} - {2'b00, dvs};
    assign last_iter = (counter == CW'(XLEN - 1));

    assign quo_fix = (ns1 ^ ns2) ? -q : q;
    assign rem_fix = ns1 ? -r[XLEN-1:0] : r[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (div_zero || overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Special cases write their results at acceptance; quo/rem otherwise hold until FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            r       <= '0;
            q       <= '0;
            dvs     <= '0;
            ns1     <= 1'b0;
            ns2     <= 1'b0;
            quo     <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ns1     <= neg1_in;
                        ns2     <= neg2_in;
                        counter <= '0;
                        r       <= '0;
                        q       <= mag1_in;
                        dvs     <= mag2_in;
                        if (div_zero) begin
                            quo <= '1;
                            rem <= op1;
                        end else if (overflow) begin
                            quo <= MIN_NEG;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    counter <= counter + 1'b1;
                    if (!trial[XLEN+1]) begin
                        r <= trial[XLEN:0];
                        q <= {q[XLEN-2:0], 1'b1};
                    end else begin
                        r <= {r[XLEN-1:0], q[XLEN-1]};
                        q <= {q[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    quo <= quo_fix;
                    rem <= rem_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
